// File: rtl/layer_sequencer.sv
// layer_sequencer: handshaked producer of forward/backward layer numbers for the training loop.
// Optional wait-state watchdog is compiled in by defining LAYER_SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int LAYER_MAX        = 2,
  parameter int SAMPLE_CNT_WIDTH = 10,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SAMPLE_CNT_WIDTH-1:0] num_samples,
  output logic [LAYER_ADDR_WIDTH-1:0] fw_layer_number,
  output logic                        fw_layer_number_valid,
  input  logic                        fw_layer_number_ready,
  input  logic                        fw_ack,
  output logic [LAYER_ADDR_WIDTH-1:0] bw_layer_number,
  output logic                        bw_layer_number_valid,
  input  logic                        bw_layer_number_ready,
  input  logic                        bw_ack,
  output logic                        busy,
  output logic                        done,
  output logic [SAMPLE_CNT_WIDTH-1:0] sample_index,
  output logic                        proto_err,
  output logic                        timeout,
  output logic [2:0]                  state_dbg
);

  // Handshake: a layer number transfers on the rising edge where valid & ready are both 1.
  // valid is registered, rises the cycle after entering an ISSUE state, and holds with its
  // data until ready; ready may be high before valid. At most one layer number is in flight.

  localparam logic [LAYER_ADDR_WIDTH-1:0] K_MAX  = LAYER_ADDR_WIDTH'(LAYER_MAX);
  localparam logic [LAYER_ADDR_WIDTH-1:0] K_LAST = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FW_ISSUE = 3'd1,
    S_FW_WAIT  = 3'd2,
    S_BW_ISSUE = 3'd3,
    S_BW_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                        state, state_n;
  logic [LAYER_ADDR_WIDTH-1:0]   k, k_n;
  logic                          fw_valid_q, fw_valid_n;
  logic [LAYER_ADDR_WIDTH-1:0]   fw_layer_q, fw_layer_n;
  logic                          bw_valid_q, bw_valid_n;
  logic [LAYER_ADDR_WIDTH-1:0]   bw_layer_q, bw_layer_n;
  logic [SAMPLE_CNT_WIDTH-1:0]   samples_q, samples_n;
  logic [SAMPLE_CNT_WIDTH-1:0]   sample_idx_q, sample_idx_n;
  logic [SAMPLE_CNT_WIDTH-1:0]   sample_inc;
  logic                          proto_err_q, proto_err_n;
  logic                          done_q, done_n;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          timeout_q, timeout_n;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  assign sample_inc = sample_idx_q + SAMPLE_CNT_WIDTH'(1);

  always_comb begin
    state_n      = state;
    k_n          = k;
    fw_valid_n   = fw_valid_q;
    fw_layer_n   = fw_layer_q;
    bw_valid_n   = bw_valid_q;
    bw_layer_n   = bw_layer_q;
    samples_n    = samples_q;
    sample_idx_n = sample_idx_q;
    proto_err_n  = proto_err_q;
    done_n       = (state == S_DONE);
`ifdef LAYER_SEQ_TIMEOUT_EN
    timeout_n    = timeout_q;
    wait_cnt_n   = '0;
`endif
    case (state)
      S_IDLE: begin
        fw_valid_n = 1'b0;
        bw_valid_n = 1'b0;
        if (start) begin
          samples_n    = num_samples;
          sample_idx_n = '0;
          proto_err_n  = 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
          timeout_n    = 1'b0;
`endif
          k_n          = '0;
          state_n      = (num_samples == '0) ? S_DONE : S_FW_ISSUE;
        end
      end
      S_FW_ISSUE: begin
        if (!fw_valid_q) begin
          fw_valid_n = 1'b1;
          fw_layer_n = k;
        end else if (fw_layer_number_ready) begin
          fw_valid_n = 1'b0;
          state_n    = S_FW_WAIT;
        end
      end
      S_FW_WAIT: begin
        if (fw_ack) begin
          if (k < K_MAX) begin
            k_n     = k + LAYER_ADDR_WIDTH'(1);
            state_n = S_FW_ISSUE;
          end else begin
            k_n     = K_LAST;
            state_n = S_BW_ISSUE;
          end
        end
      end
      S_BW_ISSUE: begin
        if (!bw_valid_q) begin
          bw_valid_n = 1'b1;
          bw_layer_n = k;
        end else if (bw_layer_number_ready) begin
          bw_valid_n = 1'b0;
          state_n    = S_BW_WAIT;
        end
      end
      S_BW_WAIT: begin
        if (bw_ack) begin
          if (k != '0) begin
            k_n     = k - LAYER_ADDR_WIDTH'(1);
            state_n = S_BW_ISSUE;
          end else begin
            sample_idx_n = sample_inc;
            k_n          = '0;
            state_n      = (sample_inc == samples_q) ? S_DONE : S_FW_ISSUE;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Acks outside their own WAIT state are dropped but remembered.
    if (fw_ack && (state != S_FW_WAIT)) proto_err_n = 1'b1;
    if (bw_ack && (state != S_BW_WAIT)) proto_err_n = 1'b1;

`ifdef LAYER_SEQ_TIMEOUT_EN
    if (((state == S_FW_WAIT) && !fw_ack) || ((state == S_BW_WAIT) && !bw_ack)) begin
      if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout_n = 1'b1;
        state_n   = S_IDLE;
      end else begin
        wait_cnt_n = wait_cnt + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      k            <= '0;
      fw_valid_q   <= 1'b0;
      fw_layer_q   <= '0;
      bw_valid_q   <= 1'b0;
      bw_layer_q   <= '0;
      samples_q    <= '0;
      sample_idx_q <= '0;
      proto_err_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      fw_valid_q   <= fw_valid_n;
      fw_layer_q   <= fw_layer_n;
      bw_valid_q   <= bw_valid_n;
      bw_layer_q   <= bw_layer_n;
      samples_q    <= samples_n;
      sample_idx_q <= sample_idx_n;
      proto_err_q  <= proto_err_n;
      done_q       <= done_n;
    end
  end

`ifdef LAYER_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_n;
      timeout_q <= timeout_n;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign fw_layer_number       = fw_layer_q;
  assign fw_layer_number_valid = fw_valid_q;
  assign bw_layer_number       = bw_layer_q;
  assign bw_layer_number_valid = bw_valid_q;
  assign busy                  = (state != S_IDLE);
  assign done                  = done_q;
  assign sample_index          = sample_idx_q;
  assign proto_err             = proto_err_q;
  assign state_dbg             = state;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed + randomized bench for layer_sequencer with a transfer-order model.
// Watchdog expectations follow LAYER_SEQ_TIMEOUT_EN.
module tb_layer_sequencer;

  localparam int LAW  = 2;
  localparam int LMAX = 2;
  localparam int SCW  = 10;
  localparam int TOC  = 1024;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [SCW-1:0] num_samples;
  logic [LAW-1:0] fw_layer, bw_layer;
  logic           fw_valid, fw_ready, fw_ack;
  logic           bw_valid, bw_ready, bw_ack;
  logic           busy, done, proto_err, timeout;
  logic [SCW-1:0] sample_index;
  logic [2:0]     state_dbg;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  // Expected transfer order: {is_bw, layer}
  logic [LAW:0] exp_q[$];

  layer_sequencer #(
    .LAYER_ADDR_WIDTH(LAW), .LAYER_MAX(LMAX), .SAMPLE_CNT_WIDTH(SCW), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .fw_layer_number(fw_layer), .fw_layer_number_valid(fw_valid),
    .fw_layer_number_ready(fw_ready), .fw_ack(fw_ack),
    .bw_layer_number(bw_layer), .bw_layer_number_valid(bw_valid),
    .bw_layer_number_ready(bw_ready), .bw_ack(bw_ack),
    .busy(busy), .done(done), .sample_index(sample_index),
    .proto_err(proto_err), .timeout(timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: one sample is forward 0..LMAX, then backward LMAX-1..0.
  task automatic push_run(input int n);
    for (int s = 0; s < n; s++) begin
      for (int l = 0; l <= LMAX; l++) exp_q.push_back({1'b0, LAW'(l)});
      for (int l = LMAX - 1; l >= 0; l--) exp_q.push_back({1'b1, LAW'(l)});
    end
  endtask

  // Monitor: transfer order, valid exclusivity, hold-until-ready stability, done pulses.
  logic           hold_fw = 1'b0, hold_bw = 1'b0;
  logic [LAW-1:0] last_fw, last_bw;
  logic [31:0]    exp_v;
  always @(negedge clk) begin
    if (!rst) begin
      hold_fw = 1'b0;
      hold_bw = 1'b0;
    end else begin
      check("valid_exclusive", 32'(fw_valid && bw_valid), 32'd0);
      if (hold_fw) begin
        check("fw_hold_valid", 32'(fw_valid), 32'd1);
        check("fw_hold_layer", 32'(fw_layer), 32'(last_fw));
      end
      if (hold_bw) begin
        check("bw_hold_valid", 32'(bw_valid), 32'd1);
        check("bw_hold_layer", 32'(bw_layer), 32'(last_bw));
      end
      if (fw_valid && fw_ready) begin
        xfer_cnt++;
        exp_v = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF;
        check("fw_xfer", 32'({1'b0, fw_layer}), exp_v);
      end
      if (bw_valid && bw_ready) begin
        xfer_cnt++;
        exp_v = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF;
        check("bw_xfer", 32'({1'b1, bw_layer}), exp_v);
      end
      hold_fw = fw_valid && !fw_ready;
      hold_bw = bw_valid && !bw_ready;
      last_fw = fw_layer;
      last_bw = bw_layer;
      if (done) done_cnt++;
    end
  end

  // All main-thread driving happens 1 time unit after a rising edge.
  task automatic do_start(input int n);
    num_samples = SCW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Datapath responder: acks each transfer after ack_dly cycles (0 = random 1..4).
  task automatic run_auto(input int budget, input bit rand_ready, input int ack_dly,
                          input bit stop_at_bw, output bit finished);
    int ack_cnt;
    bit ack_bw, xf, xb, seen_done;
    ack_cnt = 0; ack_bw = 1'b0; finished = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      @(negedge clk);
      xf = fw_valid && fw_ready;
      xb = bw_valid && bw_ready;
      seen_done = done;
      @(posedge clk); #1;
      fw_ack = 1'b0; bw_ack = 1'b0; start = 1'b0;
      if (seen_done || (stop_at_bw && xb)) begin
        finished = 1'b1;
      end else begin
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) begin
            if (ack_bw) bw_ack = 1'b1;
            else fw_ack = 1'b1;
          end
        end
        if (xf || xb) begin
          ack_cnt = (ack_dly == 0) ? int'($urandom_range(1, 4)) : ack_dly;
          ack_bw = xb;
        end
        fw_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        bw_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (busy) start = ($urandom_range(0, 3) == 0);
      end
    end
    fw_ack = 1'b0; bw_ack = 1'b0; start = 1'b0;
  endtask

  task automatic wait_fw_xfer(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = fw_valid && fw_ready;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_run_end(input string tag, input int n, input int d0, input bit fin);
    check({tag, "_finished"}, 32'(fin), 32'd1);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_sample_index"}, 32'(sample_index), 32'(n));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_all_xfers"}, 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_no_extra_done"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, x0, n;
    bit fin, ok;
    rst = 1'b0; start = 1'b0; num_samples = '0;
    fw_ready = 1'b0; bw_ready = 1'b0; fw_ack = 1'b0; bw_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fw_valid", 32'(fw_valid), 32'd0);
    check("rst_bw_valid", 32'(bw_valid), 32'd0);
    check("rst_fw_layer", 32'(fw_layer), 32'd0);
    check("rst_bw_layer", 32'(bw_layer), 32'd0);
    check("rst_sample_index", 32'(sample_index), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single sample, start latency, ready held low for 10 cycles, ack 3 cycles after transfer.
    push_run(1); d0 = done_cnt; x0 = xfer_cnt;
    do_start(1);
    check("lat_valid_c1", 32'(fw_valid), 32'd0);
    check("lat_busy_c1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat_valid_c2", 32'(fw_valid), 32'd1);
    check("lat_layer_c2", 32'(fw_layer), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(fw_valid), 32'd1);
      check("stall_layer", 32'(fw_layer), 32'd0);
    end
    fw_ready = 1'b1;
    run_auto(2000, 1'b0, 3, 1'b0, fin);
    check("one_sample_xfers", 32'(xfer_cnt - x0), 32'd5);
    check_run_end("one_sample", 1, d0, fin);

    // Three samples: 15 transfers in (0,1,2 | 1,0) x3 order.
    push_run(3); d0 = done_cnt; x0 = xfer_cnt;
    do_start(3);
    run_auto(2000, 1'b0, 3, 1'b0, fin);
    check("three_sample_xfers", 32'(xfer_cnt - x0), 32'd15);
    check_run_end("three_sample", 3, d0, fin);

    // Randomized runs: random ready, ack delay, and start pulses while busy.
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 5));
      push_run(n); d0 = done_cnt; x0 = xfer_cnt;
      do_start(n);
      run_auto(3000, 1'b1, 0, 1'b0, fin);
      check("rand_xfers", 32'(xfer_cnt - x0), 32'(5 * n));
      check("rand_proto_err", 32'(proto_err), 32'd0);
      check_run_end("rand", n, d0, fin);
    end

    // Stray acks: fw_ack in IDLE, then bw_ack in FW_WAIT.
    fw_ack = 1'b1;
    @(posedge clk); #1;
    fw_ack = 1'b0;
    check("proto_idle_set", 32'(proto_err), 32'd1);
    check("proto_idle_busy", 32'(busy), 32'd0);
    push_run(1); d0 = done_cnt;
    fw_ready = 1'b1;
    do_start(1);
    check("proto_cleared_by_start", 32'(proto_err), 32'd0);
    wait_fw_xfer(ok);
    check("proto_reach_fw_wait", 32'(ok), 32'd1);
    bw_ack = 1'b1;
    @(posedge clk); #1;
    bw_ack = 1'b0;
    check("proto_fwwait_set", 32'(proto_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("proto_still_busy", 32'(busy), 32'd1);
    check("proto_no_fw_valid", 32'(fw_valid), 32'd0);
    check("proto_no_bw_valid", 32'(bw_valid), 32'd0);
    fw_ack = 1'b1;
    @(posedge clk); #1;
    fw_ack = 1'b0;
    run_auto(2000, 1'b0, 2, 1'b0, fin);
    check("proto_sticky", 32'(proto_err), 32'd1);
    check_run_end("proto_run", 1, d0, fin);

    // Zero samples: no valids, done two cycles after start.
    d0 = done_cnt; x0 = xfer_cnt;
    do_start(0);
    check("zero_c1_done", 32'(done), 32'd0);
    check("zero_c1_busy", 32'(busy), 32'd1);
    check("zero_clears_proto", 32'(proto_err), 32'd0);
    @(posedge clk); #1;
    check("zero_c2_done", 32'(done), 32'd1);
    check("zero_c2_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("zero_c3_done", 32'(done), 32'd0);
    check("zero_no_xfers", 32'(xfer_cnt - x0), 32'd0);
    check("zero_done_once", 32'(done_cnt - d0), 32'd1);
    check("zero_sample_index", 32'(sample_index), 32'd0);

    // Reset asserted in BW_WAIT: immediate return to reset values.
    push_run(1);
    do_start(1);
    run_auto(2000, 1'b1, 0, 1'b1, fin);
    check("rst_mid_reached_bw_wait", 32'(fin), 32'd1);
    check("rst_mid_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_fw_valid", 32'(fw_valid), 32'd0);
    check("rst_mid_bw_valid", 32'(bw_valid), 32'd0);
    check("rst_mid_bw_layer", 32'(bw_layer), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Missing ack: watchdog behaviour depends on the build.
    push_run(1); d0 = done_cnt;
    fw_ready = 1'b1;
    do_start(1);
    wait_fw_xfer(ok);
    check("wd_reach_fw_wait", 32'(ok), 32'd1);
`ifdef LAYER_SEQ_TIMEOUT_EN
    repeat (TOC - 1) @(posedge clk);
    #1;
    check("wd_before_timeout", 32'(timeout), 32'd0);
    check("wd_before_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("wd_timeout", 32'(timeout), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("wd_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    do_start(0);
    check("wd_start_clears", 32'(timeout), 32'd0);
    repeat (3) @(posedge clk);
    #1;
`else
    repeat (TOC + 100) @(posedge clk);
    #1;
    check("nowd_timeout", 32'(timeout), 32'd0);
    check("nowd_still_busy", 32'(busy), 32'd1);
    fw_ack = 1'b1;
    @(posedge clk); #1;
    fw_ack = 1'b0;
    run_auto(2000, 1'b1, 0, 1'b0, fin);
    check_run_end("nowd_run", 1, d0, fin);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
